// File: rtl/prog_load_ctrl.sv
// Loads host program words into the 4-bit core's program memory, then runs the core for a fixed budget.
// Latency: a write strobe follows an accepted word by 1 cycle; load_ready deasserts while memory is full or the final write is pending.
module prog_load_ctrl #(
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 5,
  parameter int RST_CYCLES = 2,
  parameter int RUN_CYCLES = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [3:0]       load_opcode,
  input  logic [3:0]       load_operand,
  input  logic             load_last,
  input  logic             start,
  input  logic             abort,
  output logic             mem_write,
  output logic [3:0]       instr,
  output logic [3:0]       portin,
  output logic             PC_reset,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] word_count,
  output logic             overflow_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRELOAD, S_LOAD, S_LOADED, S_PCRST, S_RUN, S_DONE
  } state_t;

  localparam int CYC_MAX = (RST_CYCLES > RUN_CYCLES) ? RST_CYCLES : RUN_CYCLES;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] RUN_LAST = CYC_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  state_t           state, state_n;
  logic [CYC_W-1:0] cyc, cyc_n;
  logic             last_pend, pend_n;
  logic [CNT_W-1:0] count_n;
  logic             ovf_n, wr_n;
  logic [3:0]       instr_n, portin_n;
  logic             accept;

  assign accept = (state == S_LOAD) && load_valid && load_ready;

  always_comb begin
    state_n  = state;
    cyc_n    = cyc;
    pend_n   = 1'b0;
    count_n  = word_count;
    ovf_n    = overflow_err;
    wr_n     = 1'b0;
    instr_n  = instr;
    portin_n = portin;
    if (abort) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_LOADED, S_DONE: begin
          if (load_valid) begin
            state_n = S_PRELOAD;
            count_n = '0;
            ovf_n   = 1'b0;
          end else if (start && (word_count != '0)) begin
            state_n = S_PCRST;
            cyc_n   = RST_LAST;
          end
        end
        S_PRELOAD: state_n = S_LOAD;
        S_LOAD: begin
          // The final word's write cycle still belongs to LOAD; leave afterwards.
          if (last_pend) begin
            state_n = S_LOADED;
          end else if (accept) begin
            wr_n     = 1'b1;
            instr_n  = load_opcode;
            portin_n = load_operand;
            count_n  = word_count + 1'b1;
            pend_n   = load_last;
          end else if (load_valid && (word_count == DEPTH_C)) begin
            ovf_n   = 1'b1;
            state_n = S_LOADED;
          end
        end
        S_PCRST: begin
          if (cyc == '0) begin
            state_n = S_RUN;
            cyc_n   = RUN_LAST;
          end else begin
            cyc_n = cyc - 1'b1;
          end
        end
        S_RUN: begin
          if (cyc == '0) state_n = S_DONE;
          else           cyc_n   = cyc - 1'b1;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cyc          <= '0;
      last_pend    <= 1'b0;
      load_ready   <= 1'b0;
      mem_write    <= 1'b0;
      instr        <= '0;
      portin       <= '0;
      PC_reset     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      word_count   <= '0;
      overflow_err <= 1'b0;
    end else begin
      state        <= state_n;
      cyc          <= cyc_n;
      last_pend    <= pend_n;
      load_ready   <= (state_n == S_LOAD) && !pend_n && (count_n < DEPTH_C);
      mem_write    <= wr_n;
      instr        <= instr_n;
      portin       <= portin_n;
      PC_reset     <= !((state_n == S_LOAD) || (state_n == S_RUN));
      busy         <= !((state_n == S_IDLE) || (state_n == S_LOADED) || (state_n == S_DONE));
      done         <= (state_n == S_DONE);
      word_count   <= count_n;
      overflow_err <= ovf_n;
    end
  end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed + randomized bench for prog_load_ctrl: two instances (DEPTH 16 and DEPTH 4).
module tb_prog_load_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic       a_valid, a_last, a_start, a_abort;
  logic [3:0] a_op, a_opd;
  logic       a_ready, a_wr, a_pcrst, a_busy, a_done, a_ovf;
  logic [3:0] a_instr, a_portin;
  logic [4:0] a_cnt;

  logic       b_valid, b_last, b_start, b_abort;
  logic [3:0] b_op, b_opd;
  logic       b_ready, b_wr, b_pcrst, b_busy, b_done, b_ovf;
  logic [3:0] b_instr, b_portin;
  logic [2:0] b_cnt;

  prog_load_ctrl #(.DEPTH(16), .CNT_W(5), .RST_CYCLES(2), .RUN_CYCLES(20)) dut_a (
    .clk(clk), .reset_n(reset_n), .load_valid(a_valid), .load_ready(a_ready),
    .load_opcode(a_op), .load_operand(a_opd), .load_last(a_last), .start(a_start),
    .abort(a_abort), .mem_write(a_wr), .instr(a_instr), .portin(a_portin),
    .PC_reset(a_pcrst), .busy(a_busy), .done(a_done), .word_count(a_cnt),
    .overflow_err(a_ovf));

  prog_load_ctrl #(.DEPTH(4), .CNT_W(3), .RST_CYCLES(2), .RUN_CYCLES(20)) dut_b (
    .clk(clk), .reset_n(reset_n), .load_valid(b_valid), .load_ready(b_ready),
    .load_opcode(b_op), .load_operand(b_opd), .load_last(b_last), .start(b_start),
    .abort(b_abort), .mem_write(b_wr), .instr(b_instr), .portin(b_portin),
    .PC_reset(b_pcrst), .busy(b_busy), .done(b_done), .word_count(b_cnt),
    .overflow_err(b_ovf));

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] prog[$];
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;
  int a_writes = 0;
  int b_writes = 0;
  bit mon_en = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest accepted word.
  always @(negedge clk) begin
    if (reset_n && mon_en && a_wr) begin
      a_writes++;
      check("A write had pending word", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("A write order/data", {a_instr, a_portin}, mon_e);
      end
    end
    if (reset_n && b_wr) b_writes++;
  end

  // Presents prog[] to DUT A; gaps inserts random idle cycles on load_valid.
  task automatic load_a(input bit gaps);
    int idx = 0;
    int guard = 0;
    bit hs;
    while (idx < prog.size() && guard < 2000) begin
      if (!gaps || $urandom_range(0, 2) != 0) begin
        a_valid = 1'b1;
        a_op    = prog[idx][7:4];
        a_opd   = prog[idx][3:0];
        a_last  = (idx == prog.size() - 1);
      end else begin
        a_valid = 1'b0;
        a_op    = 4'($urandom);
        a_opd   = 4'($urandom);
        a_last  = 1'($urandom);
      end
      hs = a_valid && a_ready;
      if (hs) exp_q.push_back(prog[idx]);
      @(negedge clk);
      guard++;
      check("A write strobe follows accept", a_wr, hs);
      if (hs) begin
        check("A write data 1 cycle after accept", {a_instr, a_portin}, prog[idx]);
        check("A PC_reset low while loading", a_pcrst, 0);
        idx++;
      end
    end
    a_valid = 1'b0;
    a_last  = 1'b0;
    check("A load completed in budget", guard < 2000, 1);
  endtask

  // Pulses start and measures PCRST-high and RUN-low cycles until done (or abort).
  task automatic run_a(input int abort_at, output int hi, output int lo);
    hi = 0;
    lo = 0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (a_done) break;
      if (!a_pcrst) lo++;
      else if (a_busy) hi++;
      if (abort_at > 0 && lo == abort_at) begin
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int hi, lo, base, idx;
    bit hs;
    reset_n = 1'b0;
    {a_valid, a_last, a_start, a_abort, a_op, a_opd} = '0;
    {b_valid, b_last, b_start, b_abort, b_op, b_opd} = '0;
    repeat (3) @(negedge clk);
    check("reset load_ready", a_ready, 0);
    check("reset mem_write", a_wr, 0);
    check("reset PC_reset", a_pcrst, 1);
    check("reset busy/done/ovf", {a_busy, a_done, a_ovf}, 0);
    check("reset instr/portin/count", {a_instr, a_portin, a_cnt}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // start with nothing loaded is ignored
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    @(negedge clk);
    check("start with count 0 ignored", {a_busy, a_pcrst}, 2'b01);

    // Fixed 9-word program
    prog = '{8'h63, 8'h40, 8'h63, 8'h41, 8'h50, 8'h80, 8'h51, 8'h00, 8'h70};
    load_a(1'b0);
    repeat (3) @(negedge clk);
    check("T1 write count", a_writes, 9);
    check("T1 scoreboard drained", exp_q.size(), 0);
    check("T1 word_count", a_cnt, 9);
    check("T1 LOADED idle", {a_busy, a_ready, a_pcrst, a_done}, 4'b0010);

    run_a(0, hi, lo);
    check("T2 PC_reset high cycles", hi, 2);
    check("T2 PC_reset low cycles", lo, 20);
    check("T2 done", a_done, 1);
    repeat (5) @(negedge clk);
    check("T2 done held", {a_done, a_busy, a_pcrst}, 3'b101);

    // DEPTH=4 overflow
    idx = 0;
    for (int i = 0; i < 40 && !b_ovf; i++) begin
      b_valid = 1'b1;
      b_op    = 4'(idx + 1);
      b_opd   = 4'(idx + 8);
      hs = b_valid && b_ready;
      @(negedge clk);
      if (hs) begin
        idx++;
        if (idx == 4) check("T3 ready low after 4th", b_ready, 0);
      end
    end
    b_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("T3 accepted words", idx, 4);
    check("T3 writes", b_writes, 4);
    check("T3 word_count", b_cnt, 4);
    check("T3 overflow sticky", b_ovf, 1);
    check("T3 LOADED", {b_busy, b_ready}, 2'b00);

    // Random program with backpressure gaps, loaded from DONE
    prog.delete();
    for (int i = 0; i < 12; i++) prog.push_back(8'($urandom));
    base = a_writes;
    load_a(1'b1);
    repeat (3) @(negedge clk);
    check("T4 write count", a_writes - base, 12);
    check("T4 scoreboard drained", exp_q.size(), 0);
    check("T4 word_count", a_cnt, 12);
    check("T4 LOADED", {a_busy, a_done, a_ovf}, 0);

    // Abort mid-run, then rerun
    run_a(10, hi, lo);
    check("T5 low cycles before abort", lo, 10);
    check("T5 abort to IDLE", {a_busy, a_pcrst, a_done, a_wr}, 4'b0100);
    check("T5 count retained", a_cnt, 12);
    @(negedge clk);
    run_a(0, hi, lo);
    check("T5 rerun PC_reset high", hi, 2);
    check("T5 rerun full budget", lo, 20);
    check("T5 rerun done", a_done, 1);

    // Async reset mid-load
    mon_en = 1'b0;
    a_valid = 1'b1;
    a_op = 4'hA;
    a_opd = 4'h5;
    repeat (4) @(negedge clk);
    check("T6 in LOAD before reset", {a_busy, a_pcrst}, 2'b10);
    #2;
    reset_n = 1'b0;
    #1;
    check("T6 reset ready/write", {a_ready, a_wr}, 0);
    check("T6 reset PC_reset", a_pcrst, 1);
    check("T6 reset busy/done/ovf", {a_busy, a_done, a_ovf}, 0);
    check("T6 reset instr/portin/count", {a_instr, a_portin, a_cnt}, 0);
    a_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
